// File: rtl/rv32_rst_pkg.sv
// Shared types and default constants for the rv32 reset/run sequencer.
package rv32_rst_pkg;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGGER     = 4;
    localparam int DEF_CNT_W       = 32;

    typedef enum logic [2:0] {
        RESET   = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4
    } rst_state_t;

    // One width serves both the hold counter and the stagger gap counter.
    function automatic int down_cnt_w(input int hold, input int stagger, input int ndom);
        int span;
        span = (hold > stagger * ndom) ? hold : stagger * ndom;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/rv32_rst_stagger.sv
// Staggered per-domain reset release: bit 0 clears on the start strobe,
// each higher bit clears STAGGER cycles after the one below it.
module rv32_rst_stagger
    import rv32_rst_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int DC_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   start_i,
    output logic [NUM_DOMAINS-1:0] dom_rst_o
);

    localparam logic [NUM_DOMAINS-1:0] ALL_ONES = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] ALL_ZERO = {NUM_DOMAINS{1'b0}};
    localparam logic [DC_W-1:0]        GAP_LOAD = DC_W'(STAGGER - 1);
    localparam logic [DC_W-1:0]        GAP_ZERO = {DC_W{1'b0}};

    logic [NUM_DOMAINS-1:0] dom_d;
    logic [DC_W-1:0]        gap_q;
    logic [DC_W-1:0]        gap_d;

    // Next release mask and gap count; the mask shifts left so zeros fill from bit 0.
    always_comb begin
        dom_d = dom_rst_o;
        gap_d = gap_q;
        if (clear_i) begin
            dom_d = ALL_ONES;
            gap_d = GAP_ZERO;
        end else if (start_i) begin
            dom_d = ALL_ONES << 1;
            gap_d = GAP_LOAD;
        end else if ((dom_rst_o != ALL_ZERO) && (dom_rst_o != ALL_ONES)) begin
            if (gap_q == GAP_ZERO) begin
                dom_d = dom_rst_o << 1;
                gap_d = GAP_LOAD;
            end else begin
                gap_d = gap_q - DC_W'(1);
            end
        end else begin
            dom_d = dom_rst_o;
            gap_d = gap_q;
        end
    end

    // Release mask and gap counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dom_rst_o <= ALL_ONES;
            gap_q     <= GAP_ZERO;
        end else begin
            dom_rst_o <= dom_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: rtl/rv32_rst_seq.sv
// Reset/run sequencer: stretched reset hold, staggered domain release,
// core clock-enable and a run-cycle counter that halts at a programmable limit.
module rv32_rst_seq
    import rv32_rst_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    input  logic [CNT_W-1:0]       run_limit,
    input  logic                   pause,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   clk_en,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic                   busy,
    output logic                   done
);

    localparam int                     DC_W      = down_cnt_w(HOLD_CYCLES, STAGGER, NUM_DOMAINS);
    localparam logic [DC_W-1:0]        HOLD_LOAD = DC_W'(HOLD_CYCLES - 1);
    localparam logic [DC_W-1:0]        DC_ZERO   = {DC_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] DOM_ZERO  = {NUM_DOMAINS{1'b0}};

    rst_state_t       state_q;
    logic [DC_W-1:0]  hold_q;
    logic             clk_en_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic             soft_s;
    logic             release_go_s;
    logic [CNT_W-1:0] cnt_d;
    logic             limit_hit_s;

    // Soft reset is meaningless before the first hold has started.
    assign soft_s       = soft_rst_req && (state_q != RESET);
    assign release_go_s = (state_q == HOLD) && (hold_q == DC_ZERO);

    // Saturating count of enabled cycles; >= also catches a limit lowered below the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clk_en_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        limit_hit_s = (run_limit != CNT_ZERO) && (cnt_d >= run_limit);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RESET;
            hold_q   <= DC_ZERO;
            clk_en_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (soft_s) begin
            state_q  <= HOLD;
            hold_q   <= HOLD_LOAD;
            clk_en_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    state_q <= HOLD;
                    hold_q  <= HOLD_LOAD;
                end
                HOLD: begin
                    if (hold_q == DC_ZERO) begin
                        state_q <= RELEASE;
                    end else begin
                        hold_q <= hold_q - DC_W'(1);
                    end
                end
                RELEASE: begin
                    if (dom_rst == DOM_ZERO) begin
                        state_q  <= RUN;
                        clk_en_q <= ~pause;
                        busy_q   <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (limit_hit_s) begin
                        state_q  <= HALT;
                        clk_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        clk_en_q <= ~pause;
                    end
                end
                HALT: begin
                    clk_en_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q  <= RESET;
                    clk_en_q <= 1'b0;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    rv32_rst_stagger #(
        .NUM_DOMAINS(NUM_DOMAINS),
        .STAGGER    (STAGGER),
        .DC_W       (DC_W)
    ) u_stagger (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (soft_s),
        .start_i  (release_go_s),
        .dom_rst_o(dom_rst)
    );

    assign clk_en    = clk_en_q;
    assign cycle_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
